// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the CPU data stage (D),
//   the CPU fetch stage (F) and the external loader/debug port (L).
//   The fixed priority is D > F > L. A starvation counter promotes L to top
//   priority after STARVE_LIMIT consecutive denied L-request cycles. Read data
//   is routed back to the port that issued the read, READ_LATENCY cycles after
//   its grant.
//
// Ports
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_{d,f,l}_req             access requests
//   i_{d,l}_rw                0 = read, 1 = write (F only reads)
//   i_{d,f,l}_addr            16-bit byte addresses
//   i_{d,l}_wdata             32-bit write data
//   o_{d,f,l}_gnt             access issued to memory this cycle
//   o_{d,f,l}_rdata/_rvalid   read return (rdata is 0 while rvalid is low)
//   o_stall                   a CPU port (D or F) lost arbitration this cycle
//   o_mem_*                   memory strobe, direction, address and write data
//   i_mem_data                memory read data, READ_LATENCY cycles after a read

module mem_port_arbiter #(
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_d_req,
   input  logic        i_f_req,
   input  logic        i_l_req,
   input  logic        i_d_rw,
   input  logic        i_l_rw,
   input  logic [15:0] i_d_addr,
   input  logic [15:0] i_f_addr,
   input  logic [15:0] i_l_addr,
   input  logic [31:0] i_d_wdata,
   input  logic [31:0] i_l_wdata,
   output logic        o_d_gnt,
   output logic        o_f_gnt,
   output logic        o_l_gnt,
   output logic [31:0] o_d_rdata,
   output logic [31:0] o_f_rdata,
   output logic [31:0] o_l_rdata,
   output logic        o_d_rvalid,
   output logic        o_f_rvalid,
   output logic        o_l_rvalid,
   output logic        o_stall,
   output logic        o_mem_en,
   output logic        o_mem_rw,
   output logic [15:0] o_mem_address,
   output logic [31:0] o_mem_data,
   input  logic [31:0] i_mem_data
);

   localparam logic [7:0]  StarveMax = 8'(STARVE_LIMIT);
   localparam int unsigned PortW     = 2 * READ_LATENCY;

   localparam logic [1:0] PortD = 2'd0;
   localparam logic [1:0] PortF = 2'd1;
   localparam logic [1:0] PortL = 2'd2;

   logic [7:0]                   starve_cnt_q, starve_cnt_d;
   logic [READ_LATENCY-1:0]      ret_vld_q, ret_vld_d;
   logic [READ_LATENCY-1:0][1:0] ret_port_q, ret_port_d;

   logic       promote;
   logic       d_gnt, f_gnt, l_gnt;
   logic       new_vld;
   logic [1:0] new_port;
   logic       tail_vld;
   logic [1:0] tail_port;

   // Arbitration. Everything is forced idle while reset is held so that no
   // strobe reaches the memory during reset.
   always_comb begin
      promote = (starve_cnt_q == StarveMax);
      d_gnt   = 1'b0;
      f_gnt   = 1'b0;
      l_gnt   = 1'b0;
      if (i_reset_n) begin
         if (promote && i_l_req) begin
            l_gnt = 1'b1;
         end else if (i_d_req) begin
            d_gnt = 1'b1;
         end else if (i_f_req) begin
            f_gnt = 1'b1;
         end else if (i_l_req) begin
            l_gnt = 1'b1;
         end
      end
   end

   // Memory bus mux and the entry pushed into the return pipeline.
   always_comb begin
      o_mem_en      = 1'b0;
      o_mem_rw      = 1'b0;
      o_mem_address = 16'h0000;
      o_mem_data    = 32'h0000_0000;
      new_vld       = 1'b0;
      new_port      = PortD;
      if (d_gnt) begin
         o_mem_en      = 1'b1;
         o_mem_rw      = i_d_rw;
         o_mem_address = i_d_addr;
         o_mem_data    = i_d_wdata;
         new_vld       = ~i_d_rw;
         new_port      = PortD;
      end else if (f_gnt) begin
         o_mem_en      = 1'b1;
         o_mem_address = i_f_addr;
         new_vld       = 1'b1;
         new_port      = PortF;
      end else if (l_gnt) begin
         o_mem_en      = 1'b1;
         o_mem_rw      = i_l_rw;
         o_mem_address = i_l_addr;
         o_mem_data    = i_l_wdata;
         new_vld       = ~i_l_rw;
         new_port      = PortL;
      end
   end

   // Counts consecutive cycles in which L asked and was refused.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_l_req || l_gnt) begin
         starve_cnt_d = 8'd0;
      end else if (starve_cnt_q < StarveMax) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   // Return pipeline: stage 0 is the newest entry, the top stage lines up
   // with i_mem_data for that access.
   always_comb begin
      ret_vld_d  = (ret_vld_q << 1) | READ_LATENCY'(new_vld);
      ret_port_d = (ret_port_q << 2) | PortW'(new_port);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         starve_cnt_q <= 8'd0;
         ret_vld_q    <= '0;
         ret_port_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         ret_vld_q    <= ret_vld_d;
         ret_port_q   <= ret_port_d;
      end
   end

   always_comb begin
      tail_vld   = ret_vld_q[READ_LATENCY-1];
      tail_port  = ret_port_q[READ_LATENCY-1];
      o_d_gnt    = d_gnt;
      o_f_gnt    = f_gnt;
      o_l_gnt    = l_gnt;
      o_d_rvalid = tail_vld && (tail_port == PortD);
      o_f_rvalid = tail_vld && (tail_port == PortF);
      o_l_rvalid = tail_vld && (tail_port == PortL);
      o_d_rdata  = o_d_rvalid ? i_mem_data : 32'h0000_0000;
      o_f_rdata  = o_f_rvalid ? i_mem_data : 32'h0000_0000;
      o_l_rdata  = o_l_rvalid ? i_mem_data : 32'h0000_0000;
      // Only the CPU ports stall the pipeline; L losing never does.
      o_stall    = i_reset_n && ((i_d_req && !d_gnt) || (i_f_req && !f_gnt));
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with hand-computed values,
// then randomized traffic compared every cycle against a transaction-level
// model (priority list, denied-cycle streak, queue of due read returns).

module tb_mem_port_arbiter;

   localparam int unsigned RL = 3;
   localparam int unsigned SL = 3;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_d_req, i_f_req, i_l_req;
   logic        i_d_rw, i_l_rw;
   logic [15:0] i_d_addr, i_f_addr, i_l_addr;
   logic [31:0] i_d_wdata, i_l_wdata;
   logic        o_d_gnt, o_f_gnt, o_l_gnt;
   logic [31:0] o_d_rdata, o_f_rdata, o_l_rdata;
   logic        o_d_rvalid, o_f_rvalid, o_l_rvalid;
   logic        o_stall, o_mem_en, o_mem_rw;
   logic [15:0] o_mem_address;
   logic [31:0] o_mem_data;
   logic [31:0] i_mem_data;

   mem_port_arbiter #(
      .READ_LATENCY(RL),
      .STARVE_LIMIT(SL)
   ) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_d_req      (i_d_req),
      .i_f_req      (i_f_req),
      .i_l_req      (i_l_req),
      .i_d_rw       (i_d_rw),
      .i_l_rw       (i_l_rw),
      .i_d_addr     (i_d_addr),
      .i_f_addr     (i_f_addr),
      .i_l_addr     (i_l_addr),
      .i_d_wdata    (i_d_wdata),
      .i_l_wdata    (i_l_wdata),
      .o_d_gnt      (o_d_gnt),
      .o_f_gnt      (o_f_gnt),
      .o_l_gnt      (o_l_gnt),
      .o_d_rdata    (o_d_rdata),
      .o_f_rdata    (o_f_rdata),
      .o_l_rdata    (o_l_rdata),
      .o_d_rvalid   (o_d_rvalid),
      .o_f_rvalid   (o_f_rvalid),
      .o_l_rvalid   (o_l_rvalid),
      .o_stall      (o_stall),
      .o_mem_en     (o_mem_en),
      .o_mem_rw     (o_mem_rw),
      .o_mem_address(o_mem_address),
      .o_mem_data   (o_mem_data),
      .i_mem_data   (i_mem_data)
   );

   initial forever #5 i_clk = ~i_clk;

   typedef struct {
      int          due;
      int          port;
      logic [31:0] data;
   } ret_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          l_wait  = 0;
   int          exp_win = -1;
   ret_t        rq[$];
   logic [31:0] env_mem[logic [15:0]];
   logic [31:0] mdl_mem[logic [15:0]];
   logic [31:0] mpipe[RL];
   logic        cap_en, cap_rw;
   logic [15:0] cap_addr;
   logic [31:0] cap_data;

   function automatic logic [31:0] dflt(input logic [15:0] a);
      return {~a, a};
   endfunction

   function automatic logic [31:0] env_rd(input logic [15:0] a);
      return env_mem.exists(a) ? env_mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] mdl_rd(input logic [15:0] a);
      return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Called after inputs for the cycle are driven: compares every output with
   // the model and records what the memory bus carries this cycle.
   task automatic settle();
      int          win;
      logic [2:0]  req;
      logic        e_rw;
      logic [15:0] e_addr;
      logic [31:0] e_data;
      logic [2:0]  e_rv;
      logic [95:0] e_rd;
      logic        e_stall;
      i_mem_data = mpipe[RL-1];
      #1;
      win    = -1;
      req    = {i_l_req, i_f_req, i_d_req};
      if (i_reset_n) begin
         if (l_wait == int'(SL) && i_l_req) win = 2;
         else for (int k = 0; k < 3; k++) if (win < 0 && req[k]) win = k;
      end
      e_rw   = (win == 0) ? i_d_rw : (win == 2) ? i_l_rw : 1'b0;
      e_addr = (win == 0) ? i_d_addr : (win == 1) ? i_f_addr : (win == 2) ? i_l_addr : 16'h0;
      e_data = (win == 0) ? i_d_wdata : (win == 2) ? i_l_wdata : 32'h0;
      e_stall = i_reset_n && ((i_d_req && win != 0) || (i_f_req && win != 1));
      e_rv   = 3'b000;
      e_rd   = '0;
      if (i_reset_n && rq.size() > 0 && rq[0].due == cyc) begin
         e_rv[rq[0].port]         = 1'b1;
         e_rd[32*rq[0].port +: 32] = rq[0].data;
      end
      check("grants", {o_l_gnt, o_f_gnt, o_d_gnt}, (win < 0) ? 3'b000 : 3'(1 << win));
      check("stall", o_stall, e_stall);
      check("mem_bus", {o_mem_en, o_mem_rw, o_mem_address, o_mem_data},
            {win >= 0, e_rw, e_addr, e_data});
      check("rvalid", {o_l_rvalid, o_f_rvalid, o_d_rvalid}, e_rv);
      check("rdata", {o_l_rdata, o_f_rdata, o_d_rdata}, e_rd);
      exp_win  = win;
      cap_en   = o_mem_en;
      cap_rw   = o_mem_rw;
      cap_addr = o_mem_address;
      cap_data = o_mem_data;
   endtask

   // Advances the environment memory and the model across one clock edge.
   task automatic tick();
      logic [15:0] a;
      @(posedge i_clk);
      for (int i = int'(RL) - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
      mpipe[0] = (cap_en && !cap_rw) ? env_rd(cap_addr) : 32'h0;
      if (cap_en && cap_rw) env_mem[cap_addr] = cap_data;
      if (!i_reset_n) begin
         rq.delete();
         l_wait = 0;
      end else begin
         if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
         if (exp_win == 0) begin
            a = i_d_addr;
            if (i_d_rw) mdl_mem[a] = i_d_wdata;
            else rq.push_back('{cyc + int'(RL), 0, mdl_rd(a)});
         end else if (exp_win == 1) begin
            rq.push_back('{cyc + int'(RL), 1, mdl_rd(i_f_addr)});
         end else if (exp_win == 2) begin
            a = i_l_addr;
            if (i_l_rw) mdl_mem[a] = i_l_wdata;
            else rq.push_back('{cyc + int'(RL), 2, mdl_rd(a)});
         end
         if (i_l_req && exp_win != 2) l_wait = (l_wait < int'(SL)) ? l_wait + 1 : int'(SL);
         else l_wait = 0;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge i_clk);
         i_d_req = 1'b0;
         i_f_req = 1'b0;
         i_l_req = 1'b0;
         settle();
         tick();
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] v);
      env_mem[a] = v;
      mdl_mem[a] = v;
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_d_req = 1'b1; i_f_req = 1'b1; i_l_req = 1'b1;
      i_d_rw = 1'b1; i_l_rw = 1'b1;
      i_d_addr = 16'h0080; i_f_addr = 16'h0020; i_l_addr = 16'h0090;
      i_d_wdata = 32'hAAAA_0000; i_l_wdata = 32'hBBBB_0000;
      i_mem_data = 32'h0;
      for (int i = 0; i < int'(RL); i++) mpipe[i] = 32'h0;
      preload(16'h0010, 32'hDEAD_BEEF);
      preload(16'h0100, 32'h1111_1111);
      preload(16'h0104, 32'h2222_2222);
      preload(16'h0108, 32'h3333_3333);

      // Reset held with every request high.
      for (int k = 0; k < 2; k++) begin
         @(negedge i_clk);
         settle();
         check("rst_gnt", {o_l_gnt, o_f_gnt, o_d_gnt}, 3'b000);
         check("rst_quiet", {o_mem_en, o_stall, o_l_rvalid, o_f_rvalid, o_d_rvalid}, 5'b0);
         tick();
      end
      @(negedge i_clk);
      i_reset_n = 1'b1;
      settle();
      check("rel_gnt", {o_l_gnt, o_f_gnt, o_d_gnt}, 3'b001);
      check("rel_stall", o_stall, 1'b1);
      tick();
      @(negedge i_clk);
      i_d_req = 1'b0;
      settle();
      tick();
      @(negedge i_clk);
      i_f_req = 1'b0;
      settle();
      tick();
      idle(5);

      // F reads 0x0010 alone.
      @(negedge i_clk);
      i_f_req = 1'b1; i_f_addr = 16'h0010;
      settle();
      check("f_gnt", {o_l_gnt, o_f_gnt, o_d_gnt}, 3'b010);
      tick();
      for (int k = 1; k <= int'(RL); k++) begin
         @(negedge i_clk);
         i_f_req = 1'b0;
         settle();
         if (k == int'(RL)) begin
            check("f_rvalid", {o_l_rvalid, o_f_rvalid, o_d_rvalid}, 3'b010);
            check("f_rdata", o_f_rdata, 32'hDEAD_BEEF);
         end
         tick();
      end

      // D write and F read of the same word collide.
      @(negedge i_clk);
      i_d_req = 1'b1; i_d_rw = 1'b1; i_d_addr = 16'h0040; i_d_wdata = 32'h1234_5678;
      i_f_req = 1'b1; i_f_addr = 16'h0040;
      settle();
      check("dw_gnt", {o_l_gnt, o_f_gnt, o_d_gnt}, 3'b001);
      check("dw_bus", {o_mem_rw, o_mem_address, o_mem_data, o_stall},
            {1'b1, 16'h0040, 32'h1234_5678, 1'b1});
      tick();
      @(negedge i_clk);
      i_d_req = 1'b0;
      settle();
      check("fr_gnt", {o_f_gnt, o_stall}, 2'b10);
      tick();
      for (int k = 1; k <= int'(RL); k++) begin
         @(negedge i_clk);
         i_f_req = 1'b0;
         settle();
         if (k == int'(RL)) check("fr_rdata", {o_f_rvalid, o_f_rdata}, {1'b1, 32'h1234_5678});
         tick();
      end

      // L starved by a continuously requesting D.
      for (int k = 1; k <= 5; k++) begin
         @(negedge i_clk);
         i_d_req = 1'b1; i_d_rw = 1'b1; i_d_addr = 16'h0044; i_d_wdata = 32'(k);
         i_l_req = 1'b1; i_l_rw = 1'b1; i_l_addr = 16'h0048; i_l_wdata = 32'(k + 100);
         settle();
         if (k <= 3) check("starve_deny", {o_l_gnt, o_d_gnt}, 2'b01);
         if (k == 4) check("starve_promote", {o_l_gnt, o_d_gnt, o_stall}, 3'b101);
         if (k == 5) check("starve_cleared", {o_l_gnt, o_d_gnt}, 2'b01);
         tick();
      end
      idle(3);

      // D, F, L reads in consecutive cycles return in order.
      @(negedge i_clk);
      i_d_req = 1'b1; i_d_rw = 1'b0; i_d_addr = 16'h0100;
      settle();
      check("seq_d_gnt", {o_l_gnt, o_f_gnt, o_d_gnt}, 3'b001);
      tick();
      @(negedge i_clk);
      i_d_req = 1'b0; i_f_req = 1'b1; i_f_addr = 16'h0104;
      settle();
      check("seq_f_gnt", {o_l_gnt, o_f_gnt, o_d_gnt}, 3'b010);
      tick();
      @(negedge i_clk);
      i_f_req = 1'b0; i_l_req = 1'b1; i_l_rw = 1'b0; i_l_addr = 16'h0108;
      settle();
      check("seq_l_gnt", {o_l_gnt, o_f_gnt, o_d_gnt}, 3'b100);
      tick();
      for (int k = 1; k <= 3; k++) begin
         @(negedge i_clk);
         i_l_req = 1'b0;
         settle();
         if (k == 1) check("seq_d_ret", {o_l_rvalid, o_f_rvalid, o_d_rvalid, o_d_rdata},
                           {3'b001, 32'h1111_1111});
         if (k == 2) check("seq_f_ret", {o_l_rvalid, o_f_rvalid, o_d_rvalid, o_f_rdata},
                           {3'b010, 32'h2222_2222});
         if (k == 3) check("seq_l_ret", {o_l_rvalid, o_f_rvalid, o_d_rvalid, o_l_rdata},
                           {3'b100, 32'h3333_3333});
         tick();
      end
      idle(2);

      // Reset one cycle after a D read grant discards the pending return.
      @(negedge i_clk);
      i_d_req = 1'b1; i_d_rw = 1'b0; i_d_addr = 16'h0010;
      settle();
      check("rr_gnt", o_d_gnt, 1'b1);
      tick();
      @(negedge i_clk);
      i_d_req = 1'b0; i_reset_n = 1'b0;
      settle();
      tick();
      @(negedge i_clk);
      i_reset_n = 1'b1;
      settle();
      tick();
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         settle();
         check("rr_no_rvalid", o_d_rvalid, 1'b0);
         tick();
      end

      // Randomized traffic; requesters hold an access until it is granted.
      for (int n = 0; n < 3000; n++) begin
         @(negedge i_clk);
         if (!i_reset_n) i_reset_n = 1'b1;
         else if ($urandom_range(0, 249) == 0) i_reset_n = 1'b0;
         if (!i_d_req || exp_win == 0) begin
            i_d_req   = $urandom_range(0, 99) < 55;
            i_d_rw    = 1'($urandom);
            i_d_addr  = 16'($urandom_range(0, 15) * 4);
            i_d_wdata = $urandom;
         end
         if (!i_f_req || exp_win == 1) begin
            i_f_req  = $urandom_range(0, 99) < 45;
            i_f_addr = 16'($urandom_range(0, 15) * 4);
         end
         if (!i_l_req || exp_win == 2) begin
            i_l_req   = $urandom_range(0, 99) < 50;
            i_l_rw    = 1'($urandom);
            i_l_addr  = 16'($urandom_range(0, 15) * 4);
            i_l_wdata = $urandom;
         end
         settle();
         tick();
      end
      idle(int'(RL) + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory (16-bit address, 32-bit data) between three requesters: the CPU data-memory stage (D), the CPU fetch stage (F) and the external program loader/debug port (L). Fixed priority D > F > L with a starvation guard that periodically promotes L. Read data returns to the granted requester after a fixed memory latency. A stall signal tells the CPU pipeline that one of its ports lost arbitration this cycle.

## Interface
- READ_LATENCY, 1, cycles from granted read to valid i_mem_data; legal range 1-4
- STARVE_LIMIT, 8, consecutive denied L-request cycles before L is promoted to top priority; legal range 1-255
- i_clk  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_d_req, i_f_req, i_l_req  in  1 each  access request from D, F, L
- i_d_rw, i_l_rw  in  1 each  0 = read, 1 = write (F is read-only)
- i_d_addr, i_f_addr, i_l_addr  in  16 each  byte address
- i_d_wdata, i_l_wdata  in  32 each  write data
- o_d_gnt, o_f_gnt, o_l_gnt  out  1 each  access issued to memory this cycle
- o_d_rdata, o_f_rdata, o_l_rdata  out  32 each  read data, 0 when matching rvalid low
- o_d_rvalid, o_f_rvalid, o_l_rvalid  out  1 each  read-data-valid pulse
- o_stall  out  1  (i_d_req & ~o_d_gnt) | (i_f_req & ~o_f_gnt)
- o_mem_en  out  1  memory access strobe
- o_mem_rw  out  1  0 = read, 1 = write
- o_mem_address  out  16  memory address
- o_mem_data  out  32  memory write data
- i_mem_data  in  32  memory read data, valid READ_LATENCY cycles after a read strobe

## Operation
- Grant is combinational in the request cycle; at most one gnt high per cycle; o_mem_en = OR of gnts.
- Priority, normal: D, then F, then L. Promoted (r_starve_cnt == STARVE_LIMIT): L, then D, then F.
- Memory outputs mux from the granted requester; F always drives o_mem_rw = 0. With no grant: o_mem_en = 0, o_mem_rw = 0, o_mem_address = 0, o_mem_data = 0.
- Requester rule: hold req, rw, addr, wdata stable until gnt is seen high; deassert or present next access in the following cycle. Back-to-back grants to the same port are permitted.
- Starvation counter r_starve_cnt (8 bits): increments while i_l_req & ~o_l_gnt and below STARVE_LIMIT; saturates at STARVE_LIMIT; clears on o_l_gnt or when i_l_req is low.
- Return tracking: a READ_LATENCY-deep shift register of {valid, port id}. A granted read enters {1, port}; writes and idle cycles enter {0, x}. At the tail, the matching o_X_rvalid = 1 and o_X_rdata = i_mem_data. All other rdata = 0.
- o_stall is purely combinational from requests and grants; it is never set by L.

## Timing
- Reset (async assert): r_starve_cnt = 0, return shift register cleared. While reset is low, all gnt, rvalid and o_stall = 0; o_mem_en = 0; all data and address outputs = 0.
- Reset mid-read: pending returns are discarded. No rvalid is produced after reset deassertion for pre-reset grants.
- Read latency: gnt in cycle N -> rvalid in cycle N+READ_LATENCY, exactly one cycle wide.
- Throughput: one access per cycle. Reads to different ports in consecutive cycles return in order in consecutive cycles.
- L worst-case wait with D and F saturating: STARVE_LIMIT denied cycles, then granted in cycle STARVE_LIMIT+1.
- Simultaneous D and F requests: D granted and o_stall = 1 (F lost). Same cycle under promotion with L: L granted and o_stall = 1.
- Write: memory captures data in the grant cycle. No response pulse.

## Test plan
- Reset: assert i_reset_n = 0 with all reqs high -> all gnt, rvalid, o_mem_en, o_stall = 0; release -> D granted first cycle.
- F alone reads 0x0010, memory returns 0xDEADBEEF at latency 1 -> o_f_gnt in cycle N, o_f_rvalid = 1 with o_f_rdata = 0xDEADBEEF in N+1, o_d_rvalid and o_l_rvalid stay 0.
- D write 0x0040 <- 0x12345678 and F read together -> cycle N: o_d_gnt, o_mem_rw = 1, o_mem_data = 0x12345678, o_stall = 1; cycle N+1: o_f_gnt, o_stall = 0.
- STARVE_LIMIT = 3, D requests every cycle, L requests continuously -> L denied 3 cycles, o_l_gnt in 4th cycle, D denied and o_stall = 1 that cycle, counter back to 0.
- READ_LATENCY = 3, reads by D, F, L in consecutive cycles N..N+2 -> rvalid pulses D@N+3, F@N+4, L@N+5 with respective data.
- Reset asserted one cycle after a D read grant (READ_LATENCY = 2) -> no o_d_rvalid ever appears for that read.
